// File: rtl/pwm_register_bank.sv
// ---------------------------------------------------------------------------
// pwm_register_bank
//
// Register file between the I2C slave bus interface and NUM_CORES PWM cores
// (two channels per core). Every timing register has a bus-visible preload
// copy and a core-driving active copy. Preload moves to active per core on a
// counter-overflow event, immediately while the core is stopped, or on an
// explicit UPD write. A key sequence (A5, 55, AA) locks/unlocks the core
// windows. STATUS holds per-core update-pending bits plus a sticky error.
//
// Optional feature macro: PWM_REG_ACTIVE_READBACK_EN
//   defined   : reads at addr[7]=1 to a core window return the active copy
//   undefined : every addr[7]=1 address is unmapped
//
// Ports
//   clk_psc_i        clock
//   rst_n_i          synchronous active-low reset
//   wr_en_i/rd_en_i  bus write / read strobes
//   addr_i           8-bit register address
//   wr_data_i        write data (WIDTH)
//   rd_data_o        read data, valid while rd_valid_o=1, held otherwise
//   rd_valid_o       one-cycle pulse the cycle after rd_en_i
//   err_o            one-cycle pulse after a rejected or unmapped access
//   update_evt_i     per-core counter-overflow pulses
//   cen_o            counter enables
//   psc_o/arr_o      active prescaler / auto-reload, core c at [c*WIDTH +: WIDTH]
//   cmp_start_o/cmp_end_o  active compares, channel k at [k*WIDTH +: WIDTH]
//   dtg_o/cfg_o      active dead-time / config, channel k at [k*8 +: 8]
// ---------------------------------------------------------------------------
module pwm_register_bank #(
  parameter int WIDTH     = 16,
  parameter int NUM_CORES = 4
) (
  input  logic                         clk_psc_i,
  input  logic                         rst_n_i,
  input  logic                         wr_en_i,
  input  logic                         rd_en_i,
  input  logic [7:0]                   addr_i,
  input  logic [WIDTH-1:0]             wr_data_i,
  output logic [WIDTH-1:0]             rd_data_o,
  output logic                         rd_valid_o,
  output logic                         err_o,
  input  logic [NUM_CORES-1:0]         update_evt_i,
  output logic [NUM_CORES-1:0]         cen_o,
  output logic [NUM_CORES*WIDTH-1:0]   psc_o,
  output logic [NUM_CORES*WIDTH-1:0]   arr_o,
  output logic [2*NUM_CORES*WIDTH-1:0] cmp_start_o,
  output logic [2*NUM_CORES*WIDTH-1:0] cmp_end_o,
  output logic [2*NUM_CORES*8-1:0]     dtg_o,
  output logic [2*NUM_CORES*8-1:0]     cfg_o
);

  localparam int NUM_CH = 2 * NUM_CORES;

  localparam logic [WIDTH-1:0] KEY_LOCK   = WIDTH'(16'h00A5);
  localparam logic [WIDTH-1:0] KEY_STEP   = WIDTH'(16'h0055);
  localparam logic [WIDTH-1:0] KEY_UNLOCK = WIDTH'(16'h00AA);

  typedef enum logic [1:0] {
    LOCK_UNLOCKED = 2'd0,
    LOCK_LOCKED   = 2'd1,
    LOCK_KEY1     = 2'd2
  } lock_state_e;

  // Preload (bus side) and active (core side) copies
  logic [WIDTH-1:0] psc_pre_q   [NUM_CORES];
  logic [WIDTH-1:0] psc_pre_d   [NUM_CORES];
  logic [WIDTH-1:0] arr_pre_q   [NUM_CORES];
  logic [WIDTH-1:0] arr_pre_d   [NUM_CORES];
  logic [WIDTH-1:0] psc_act_q   [NUM_CORES];
  logic [WIDTH-1:0] psc_act_d   [NUM_CORES];
  logic [WIDTH-1:0] arr_act_q   [NUM_CORES];
  logic [WIDTH-1:0] arr_act_d   [NUM_CORES];
  logic [WIDTH-1:0] start_pre_q [NUM_CH];
  logic [WIDTH-1:0] start_pre_d [NUM_CH];
  logic [WIDTH-1:0] end_pre_q   [NUM_CH];
  logic [WIDTH-1:0] end_pre_d   [NUM_CH];
  logic [WIDTH-1:0] start_act_q [NUM_CH];
  logic [WIDTH-1:0] start_act_d [NUM_CH];
  logic [WIDTH-1:0] end_act_q   [NUM_CH];
  logic [WIDTH-1:0] end_act_d   [NUM_CH];
  logic [7:0]       dtg_pre_q   [NUM_CH];
  logic [7:0]       dtg_pre_d   [NUM_CH];
  logic [7:0]       cfg_pre_q   [NUM_CH];
  logic [7:0]       cfg_pre_d   [NUM_CH];
  logic [7:0]       dtg_act_q   [NUM_CH];
  logic [7:0]       dtg_act_d   [NUM_CH];
  logic [7:0]       cfg_act_q   [NUM_CH];
  logic [7:0]       cfg_act_d   [NUM_CH];

  logic [NUM_CORES-1:0] cen_q, cen_d;
  logic [NUM_CORES-1:0] pend_q, pend_d;
  logic                 serr_q, serr_d;
  lock_state_e          lock_q, lock_d;
  logic [WIDTH-1:0]     rd_data_q, rd_data_d;
  logic                 rd_valid_q, rd_valid_d;
  logic                 err_q, err_d;

  // Address decode
  logic [6:0] win_off_s;
  logic [2:0] win_core_s;
  logic [3:0] win_idx_s;
  logic       win_hit_s;

  // Read path
  logic [WIDTH-1:0] rd_val_s;
  logic             rd_err_s;
  logic             rd_win_s;
  logic             rd_act_s;

  // Write path
  logic                 wr_ctrl_s;
  logic                 wr_key_s;
  logic                 wr_stat_s;
  logic                 wr_win_s;
  logic                 wr_unmapped_s;
  logic                 locked_s;
  logic                 key_err_s;
  logic                 err_s;
  logic [NUM_CORES-1:0] pend_set_s;
  logic [NUM_CORES-1:0] upd_s;
  logic [NUM_CORES-1:0] xfer_s;

  // Core-window decode of addr_i[6:0]; callers qualify with addr_i[7].
  always_comb begin
    win_off_s  = addr_i[6:0] - 7'd8;
    win_core_s = win_off_s[6:4];
    win_idx_s  = win_off_s[3:0];
    if ((addr_i[6:0] >= 7'd8) && (int'(win_core_s) < NUM_CORES) && (win_idx_s <= 4'd10)) begin
      win_hit_s = 1'b1;
    end else begin
      win_hit_s = 1'b0;
    end
  end

  // Read data mux: preload copies, or active copies for readback addresses.
  always_comb begin
    rd_val_s = '0;
    rd_err_s = 1'b0;
    rd_win_s = 1'b0;
    rd_act_s = 1'b0;
    if (addr_i[7] == 1'b0) begin
      if (addr_i[6:0] == 7'd0) begin
        rd_val_s[NUM_CORES-1:0] = cen_q;
      end else if (addr_i[6:0] == 7'd1) begin
        rd_val_s = '0;
      end else if (addr_i[6:0] == 7'd2) begin
        rd_val_s[NUM_CORES-1:0] = pend_q;
        rd_val_s[15]            = serr_q;
      end else if (win_hit_s) begin
        rd_win_s = 1'b1;
      end else begin
        rd_err_s = 1'b1;
      end
    end else begin
`ifdef PWM_REG_ACTIVE_READBACK_EN
      if (win_hit_s) begin
        rd_win_s = 1'b1;
        rd_act_s = 1'b1;
      end else begin
        rd_err_s = 1'b1;
      end
`else
      rd_err_s = 1'b1;
`endif
    end
    if (rd_win_s) begin
      for (int c = 0; c < NUM_CORES; c++) begin
        if (win_core_s == 3'(c)) begin
          case (win_idx_s)
            4'd0:    rd_val_s = rd_act_s ? psc_act_q[c] : psc_pre_q[c];
            4'd1:    rd_val_s = rd_act_s ? arr_act_q[c] : arr_pre_q[c];
            4'd2:    rd_val_s = rd_act_s ? start_act_q[2*c] : start_pre_q[2*c];
            4'd3:    rd_val_s = rd_act_s ? end_act_q[2*c] : end_pre_q[2*c];
            4'd4:    rd_val_s = WIDTH'(rd_act_s ? dtg_act_q[2*c] : dtg_pre_q[2*c]);
            4'd5:    rd_val_s = WIDTH'(rd_act_s ? cfg_act_q[2*c] : cfg_pre_q[2*c]);
            4'd6:    rd_val_s = rd_act_s ? start_act_q[2*c+1] : start_pre_q[2*c+1];
            4'd7:    rd_val_s = rd_act_s ? end_act_q[2*c+1] : end_pre_q[2*c+1];
            4'd8:    rd_val_s = WIDTH'(rd_act_s ? dtg_act_q[2*c+1] : dtg_pre_q[2*c+1]);
            4'd9:    rd_val_s = WIDTH'(rd_act_s ? cfg_act_q[2*c+1] : cfg_pre_q[2*c+1]);
            default: rd_val_s = '0;  // UPD reads as zero
          endcase
        end else begin
          // other cores do not drive the read value
        end
      end
    end else begin
      // non-window address: value already set above
    end
  end

  // Write classification, per-core pending-set / UPD / transfer requests.
  always_comb begin
    wr_ctrl_s     = wr_en_i && (addr_i == 8'd0);
    wr_key_s      = wr_en_i && (addr_i == 8'd1);
    wr_stat_s     = wr_en_i && (addr_i == 8'd2);
    wr_win_s      = wr_en_i && !addr_i[7] && win_hit_s;
    wr_unmapped_s = wr_en_i && !(wr_ctrl_s || wr_key_s || wr_stat_s || wr_win_s);
    locked_s      = (lock_q != LOCK_UNLOCKED);
    pend_set_s    = '0;
    upd_s         = '0;
    xfer_s        = '0;
    for (int c = 0; c < NUM_CORES; c++) begin
      if (wr_win_s && !locked_s && (win_core_s == 3'(c))) begin
        pend_set_s[c] = (win_idx_s != 4'd10);
        upd_s[c]      = (win_idx_s == 4'd10);
      end else begin
        pend_set_s[c] = 1'b0;
        upd_s[c]      = 1'b0;
      end
      // A stopped core bypasses the shadow as soon as something is pending.
      xfer_s[c] = (pend_q[c] && (update_evt_i[c] || !cen_q[c])) || upd_s[c];
    end
  end

  // Lock FSM next state; in KEY1 any write other than KEY=AA relocks with error.
  always_comb begin
    lock_d    = lock_q;
    key_err_s = 1'b0;
    case (lock_q)
      LOCK_UNLOCKED: begin
        if (wr_key_s && (wr_data_i == KEY_LOCK)) begin
          lock_d = LOCK_LOCKED;
        end else begin
          lock_d = LOCK_UNLOCKED;
        end
      end
      LOCK_LOCKED: begin
        if (wr_key_s && (wr_data_i == KEY_STEP)) begin
          lock_d = LOCK_KEY1;
        end else begin
          lock_d = LOCK_LOCKED;
        end
      end
      LOCK_KEY1: begin
        if (wr_key_s && (wr_data_i == KEY_UNLOCK)) begin
          lock_d = LOCK_UNLOCKED;
        end else if (wr_en_i) begin
          lock_d    = LOCK_LOCKED;
          key_err_s = 1'b1;
        end else begin
          lock_d = LOCK_KEY1;
        end
      end
      default: begin
        lock_d = LOCK_LOCKED;
      end
    endcase
  end

  // Register next-state: preload writes, transfers, status, read pipeline.
  always_comb begin
    psc_pre_d   = psc_pre_q;
    arr_pre_d   = arr_pre_q;
    psc_act_d   = psc_act_q;
    arr_act_d   = arr_act_q;
    start_pre_d = start_pre_q;
    end_pre_d   = end_pre_q;
    start_act_d = start_act_q;
    end_act_d   = end_act_q;
    dtg_pre_d   = dtg_pre_q;
    cfg_pre_d   = cfg_pre_q;
    dtg_act_d   = dtg_act_q;
    cfg_act_d   = cfg_act_q;
    pend_d      = pend_q;

    err_s = wr_unmapped_s || (wr_win_s && locked_s) || key_err_s || (rd_en_i && rd_err_s);

    if (wr_ctrl_s) begin
      cen_d = wr_data_i[NUM_CORES-1:0];
    end else begin
      cen_d = cen_q;
    end

    for (int c = 0; c < NUM_CORES; c++) begin
      // Transfer copies the preload as it was before this cycle's write.
      if (xfer_s[c]) begin
        psc_act_d[c]       = psc_pre_q[c];
        arr_act_d[c]       = arr_pre_q[c];
        start_act_d[2*c]   = start_pre_q[2*c];
        end_act_d[2*c]     = end_pre_q[2*c];
        dtg_act_d[2*c]     = dtg_pre_q[2*c];
        cfg_act_d[2*c]     = cfg_pre_q[2*c];
        start_act_d[2*c+1] = start_pre_q[2*c+1];
        end_act_d[2*c+1]   = end_pre_q[2*c+1];
        dtg_act_d[2*c+1]   = dtg_pre_q[2*c+1];
        cfg_act_d[2*c+1]   = cfg_pre_q[2*c+1];
      end else begin
        // active copy holds
      end

      // A new write re-arms pending even if a transfer happens this cycle.
      if (pend_set_s[c]) begin
        pend_d[c] = 1'b1;
      end else if (xfer_s[c] || (wr_stat_s && wr_data_i[c])) begin
        pend_d[c] = 1'b0;
      end else begin
        pend_d[c] = pend_q[c];
      end

      if (pend_set_s[c]) begin
        case (win_idx_s)
          4'd0:    psc_pre_d[c]       = wr_data_i;
          4'd1:    arr_pre_d[c]       = wr_data_i;
          4'd2:    start_pre_d[2*c]   = wr_data_i;
          4'd3:    end_pre_d[2*c]     = wr_data_i;
          4'd4:    dtg_pre_d[2*c]     = wr_data_i[7:0];
          4'd5:    cfg_pre_d[2*c]     = wr_data_i[7:0];
          4'd6:    start_pre_d[2*c+1] = wr_data_i;
          4'd7:    end_pre_d[2*c+1]   = wr_data_i;
          4'd8:    dtg_pre_d[2*c+1]   = wr_data_i[7:0];
          4'd9:    cfg_pre_d[2*c+1]   = wr_data_i[7:0];
          default: begin
          end
        endcase
      end else begin
        // preload holds
      end
    end

    // A new error wins over a W1C of the sticky bit.
    if (err_s) begin
      serr_d = 1'b1;
    end else if (wr_stat_s && wr_data_i[15]) begin
      serr_d = 1'b0;
    end else begin
      serr_d = serr_q;
    end

    rd_valid_d = rd_en_i;
    if (rd_en_i) begin
      rd_data_d = rd_val_s;
    end else begin
      rd_data_d = rd_data_q;
    end
    err_d = err_s;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_psc_i) begin
    if (!rst_n_i) begin
      for (int c = 0; c < NUM_CORES; c++) begin
        psc_pre_q[c] <= '0;
        arr_pre_q[c] <= '1;
        psc_act_q[c] <= '0;
        arr_act_q[c] <= '1;
      end
      for (int k = 0; k < NUM_CH; k++) begin
        start_pre_q[k] <= '0;
        end_pre_q[k]   <= '0;
        start_act_q[k] <= '0;
        end_act_q[k]   <= '0;
        dtg_pre_q[k]   <= 8'd1;
        cfg_pre_q[k]   <= 8'd0;
        dtg_act_q[k]   <= 8'd1;
        cfg_act_q[k]   <= 8'd0;
      end
      cen_q      <= '0;
      pend_q     <= '0;
      serr_q     <= 1'b0;
      lock_q     <= LOCK_UNLOCKED;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      psc_pre_q   <= psc_pre_d;
      arr_pre_q   <= arr_pre_d;
      psc_act_q   <= psc_act_d;
      arr_act_q   <= arr_act_d;
      start_pre_q <= start_pre_d;
      end_pre_q   <= end_pre_d;
      start_act_q <= start_act_d;
      end_act_q   <= end_act_d;
      dtg_pre_q   <= dtg_pre_d;
      cfg_pre_q   <= cfg_pre_d;
      dtg_act_q   <= dtg_act_d;
      cfg_act_q   <= cfg_act_d;
      cen_q       <= cen_d;
      pend_q      <= pend_d;
      serr_q      <= serr_d;
      lock_q      <= lock_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      err_q       <= err_d;
    end
  end

  // Pack active copies onto the flat core-facing buses.
  always_comb begin
    psc_o       = '0;
    arr_o       = '0;
    cmp_start_o = '0;
    cmp_end_o   = '0;
    dtg_o       = '0;
    cfg_o       = '0;
    for (int c = 0; c < NUM_CORES; c++) begin
      psc_o[c*WIDTH +: WIDTH] = psc_act_q[c];
      arr_o[c*WIDTH +: WIDTH] = arr_act_q[c];
    end
    for (int k = 0; k < NUM_CH; k++) begin
      cmp_start_o[k*WIDTH +: WIDTH] = start_act_q[k];
      cmp_end_o[k*WIDTH +: WIDTH]   = end_act_q[k];
      dtg_o[k*8 +: 8]               = dtg_act_q[k];
      cfg_o[k*8 +: 8]               = cfg_act_q[k];
    end
  end

  assign cen_o      = cen_q;
  assign rd_data_o  = rd_data_q;
  assign rd_valid_o = rd_valid_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_pwm_register_bank.sv
// Self-checking bench for pwm_register_bank: directed scenarios followed by
// randomized bus traffic, all compared against a register-map level model.
module tb_pwm_register_bank;

  localparam int W   = 16;
  localparam int N   = 4;
  localparam int NCH = 2 * N;

  logic             clk_psc_i = 1'b0;
  logic             rst_n_i   = 1'b0;
  logic             wr_en_i   = 1'b0;
  logic             rd_en_i   = 1'b0;
  logic [7:0]       addr_i    = 8'd0;
  logic [W-1:0]     wr_data_i = '0;
  logic [N-1:0]     update_evt_i = '0;
  logic [W-1:0]     rd_data_o;
  logic             rd_valid_o;
  logic             err_o;
  logic [N-1:0]     cen_o;
  logic [N*W-1:0]   psc_o, arr_o;
  logic [NCH*W-1:0] cmp_start_o, cmp_end_o;
  logic [NCH*8-1:0] dtg_o, cfg_o;

  pwm_register_bank #(.WIDTH(W), .NUM_CORES(N)) dut (
    .clk_psc_i    (clk_psc_i),
    .rst_n_i      (rst_n_i),
    .wr_en_i      (wr_en_i),
    .rd_en_i      (rd_en_i),
    .addr_i       (addr_i),
    .wr_data_i    (wr_data_i),
    .rd_data_o    (rd_data_o),
    .rd_valid_o   (rd_valid_o),
    .err_o        (err_o),
    .update_evt_i (update_evt_i),
    .cen_o        (cen_o),
    .psc_o        (psc_o),
    .arr_o        (arr_o),
    .cmp_start_o  (cmp_start_o),
    .cmp_end_o    (cmp_end_o),
    .dtg_o        (dtg_o),
    .cfg_o        (cfg_o)
  );

  always #5 clk_psc_i = ~clk_psc_i;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model, indexed by window offset 0..9 within each core.
  logic [W-1:0] pre_m [N][10];
  logic [W-1:0] act_m [N][10];
  logic [N-1:0] cen_m, pend_m;
  logic         serr_m;
  int           lock_m;  // 0 unlocked, 1 locked, 2 first key seen
  logic [W-1:0] rd_data_m;
  logic         rd_valid_m, err_m;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit is_win(input int a);
    return (a >= 8) && (a < 128) && ((a - 8) / 16 < N) && ((a - 8) % 16 <= 10);
  endfunction

  function automatic logic [W-1:0] reset_val(input int idx);
    if (idx == 1) return 16'hFFFF;
    if (idx == 4 || idx == 8) return 16'h0001;
    return 16'h0000;
  endfunction

  function automatic bit is_byte(input int idx);
    return (idx == 4) || (idx == 5) || (idx == 8) || (idx == 9);
  endfunction

  // Apply one clock edge worth of bus activity to the model.
  task automatic model_edge(input bit rst_n, input bit wr, input bit rd,
                            input int a, input logic [W-1:0] d, input logic [N-1:0] evt);
    bit           err;
    logic [W-1:0] rv;
    bit   [N-1:0] xfer;
    int           old_lock, c, idx;
    if (!rst_n) begin
      for (int ci = 0; ci < N; ci++)
        for (int i = 0; i < 10; i++) begin
          pre_m[ci][i] = reset_val(i);
          act_m[ci][i] = reset_val(i);
        end
      cen_m = '0; pend_m = '0; serr_m = 1'b0; lock_m = 0;
      rd_data_m = '0; rd_valid_m = 1'b0; err_m = 1'b0;
      return;
    end
    err = 1'b0;
    if (rd) begin
      rv = '0;
      if (a == 0) rv = W'(cen_m);
      else if (a == 1) rv = '0;
      else if (a == 2) rv = {serr_m, 11'd0, pend_m};
      else if (is_win(a)) begin
        idx = (a - 8) % 16;
        if (idx < 10) rv = pre_m[(a - 8) / 16][idx];
      end
`ifdef PWM_REG_ACTIVE_READBACK_EN
      else if (a >= 128 && is_win(a - 128)) begin
        idx = (a - 136) % 16;
        if (idx < 10) rv = act_m[(a - 136) / 16][idx];
      end
`endif
      else err = 1'b1;
      rd_data_m = rv;
    end
    rd_valid_m = rd;
    xfer = '0;
    for (int ci = 0; ci < N; ci++)
      if (pend_m[ci] && (evt[ci] || !cen_m[ci])) xfer[ci] = 1'b1;
    if (wr && is_win(a) && lock_m == 0 && (a - 8) % 16 == 10) xfer[(a - 8) / 16] = 1'b1;
    for (int ci = 0; ci < N; ci++)
      if (xfer[ci]) begin
        for (int i = 0; i < 10; i++) act_m[ci][i] = pre_m[ci][i];
        pend_m[ci] = 1'b0;
      end
    old_lock = lock_m;
    if (wr) begin
      if (old_lock == 2) begin
        if (a == 1 && d == 16'h00AA) lock_m = 0;
        else begin lock_m = 1; err = 1'b1; end
      end else if (a == 1 && old_lock == 0 && d == 16'h00A5) lock_m = 1;
      else if (a == 1 && old_lock == 1 && d == 16'h0055) lock_m = 2;
      if (a == 0) cen_m = d[N-1:0];
      else if (a == 1) begin end
      else if (a == 2) begin
        pend_m &= ~d[N-1:0];
        if (d[15]) serr_m = 1'b0;
      end else if (is_win(a)) begin
        if (old_lock != 0) err = 1'b1;
        else begin
          c   = (a - 8) / 16;
          idx = (a - 8) % 16;
          if (idx < 10) begin
            pre_m[c][idx] = is_byte(idx) ? {8'h00, d[7:0]} : d;
            pend_m[c] = 1'b1;
          end
        end
      end else err = 1'b1;
    end
    if (err) serr_m = 1'b1;
    err_m = err;
  endtask

  task automatic compare_all();
    int c, j;
    check_val("rd_valid", 32'(rd_valid_o), 32'(rd_valid_m));
    check_val("rd_data", 32'(rd_data_o), 32'(rd_data_m));
    check_val("err", 32'(err_o), 32'(err_m));
    check_val("cen", 32'(cen_o), 32'(cen_m));
    for (int ci = 0; ci < N; ci++) begin
      check_val($sformatf("psc%0d", ci), 32'(psc_o[ci*W +: W]), 32'(act_m[ci][0]));
      check_val($sformatf("arr%0d", ci), 32'(arr_o[ci*W +: W]), 32'(act_m[ci][1]));
    end
    for (int k = 0; k < NCH; k++) begin
      c = k / 2;
      j = k % 2;
      check_val($sformatf("start%0d", k), 32'(cmp_start_o[k*W +: W]), 32'(act_m[c][2+4*j]));
      check_val($sformatf("end%0d", k), 32'(cmp_end_o[k*W +: W]), 32'(act_m[c][3+4*j]));
      check_val($sformatf("dtg%0d", k), 32'(dtg_o[k*8 +: 8]), 32'(act_m[c][4+4*j][7:0]));
      check_val($sformatf("cfg%0d", k), 32'(cfg_o[k*8 +: 8]), 32'(act_m[c][5+4*j][7:0]));
    end
  endtask

  task automatic cycle(input bit rst_n, input bit wr, input bit rd, input logic [7:0] a,
                       input logic [W-1:0] d, input logic [N-1:0] evt);
    rst_n_i = rst_n; wr_en_i = wr; rd_en_i = rd;
    addr_i = a; wr_data_i = d; update_evt_i = evt;
    @(posedge clk_psc_i);
    model_edge(rst_n, wr, rd, int'(a), d, evt);
    #1;
    compare_all();
  endtask

  task automatic wr_reg(input logic [7:0] a, input logic [W-1:0] d);
    cycle(1'b1, 1'b1, 1'b0, a, d, '0);
  endtask

  task automatic rd_reg(input logic [7:0] a);
    cycle(1'b1, 1'b0, 1'b1, a, '0, '0);
  endtask

  task automatic idle(input logic [N-1:0] evt);
    cycle(1'b1, 1'b0, 1'b0, 8'd0, '0, evt);
  endtask

  int           sel;
  logic [7:0]   ra;
  logic [W-1:0] rdat;
  bit           rw, rr, rrst;
  logic [N-1:0] revt;

  initial begin
    cycle(1'b0, 1'b0, 1'b0, 8'd0, '0, '0);
    cycle(1'b0, 1'b1, 1'b1, 8'd9, 16'h1234, '1);
    check_val("reset_valid", 32'(rd_valid_o), 32'd0);
    check_val("reset_arr0", 32'(arr_o[15:0]), 32'h0000FFFF);

    // reset values read back
    rd_reg(8'd9);
    check_val("tp_arr0_rd", 32'(rd_data_o), 32'h0000FFFF);
    check_val("tp_arr0_valid", 32'(rd_valid_o), 32'd1);
    check_val("tp_arr0_err", 32'(err_o), 32'd0);
    rd_reg(8'd12);
    check_val("tp_dtg0_rd", 32'(rd_data_o), 32'h00000001);

    // shadow bypass while stopped
    wr_reg(8'd24, 16'h0010);
    idle('0);
    check_val("tp_psc1_bypass", 32'(psc_o[31:16]), 32'h00000010);
    rd_reg(8'd2);
    check_val("tp_status_clear", 32'(rd_data_o), 32'h00000000);

    // buffered update while running
    wr_reg(8'd0, 16'h0001);
    wr_reg(8'd9, 16'h03E8);
    idle('0);
    check_val("tp_arr0_held", 32'(arr_o[15:0]), 32'h0000FFFF);
    rd_reg(8'd2);
    check_val("tp_status_pend", 32'(rd_data_o), 32'h00000001);
    idle(4'b0001);
    check_val("tp_arr0_loaded", 32'(arr_o[15:0]), 32'h000003E8);
    rd_reg(8'd2);
    check_val("tp_status_after", 32'(rd_data_o), 32'h00000000);

    // write colliding with the update event
    wr_reg(8'd10, 16'h0100);
    cycle(1'b1, 1'b1, 1'b0, 8'd10, 16'h0200, 4'b0001);
    check_val("tp_collide_old", 32'(cmp_start_o[15:0]), 32'h00000100);
    rd_reg(8'd2);
    check_val("tp_collide_pend", 32'(rd_data_o), 32'h00000001);
    idle(4'b0001);
    check_val("tp_collide_new", 32'(cmp_start_o[15:0]), 32'h00000200);

    // lock sequence
    wr_reg(8'd1, 16'h00A5);
    wr_reg(8'd10, 16'h1234);
    check_val("tp_locked_err", 32'(err_o), 32'd1);
    rd_reg(8'd2);
    check_val("tp_sticky_err", 32'(rd_data_o), 32'h00008000);
    rd_reg(8'd10);
    check_val("tp_locked_ignored", 32'(rd_data_o), 32'h00000200);
    wr_reg(8'd1, 16'h0055);
    wr_reg(8'd1, 16'h00AA);
    wr_reg(8'd10, 16'h1234);
    check_val("tp_unlocked_noerr", 32'(err_o), 32'd0);
    rd_reg(8'd10);
    check_val("tp_unlocked_wr", 32'(rd_data_o), 32'h00001234);
    wr_reg(8'd1, 16'h00A5);
    wr_reg(8'd1, 16'h0055);
    wr_reg(8'd0, 16'h0001);
    check_val("tp_badkey_err", 32'(err_o), 32'd1);
    wr_reg(8'd10, 16'h4321);
    check_val("tp_relocked_err", 32'(err_o), 32'd1);
    wr_reg(8'd1, 16'h0055);
    wr_reg(8'd1, 16'h00AA);
    wr_reg(8'd2, 16'h8000);
    rd_reg(8'd2);
    check_val("tp_w1c_err", 32'(rd_data_o), 32'h00000001);

    // unmapped and readback region
    rd_reg(8'd200);
    check_val("tp_unmapped_data", 32'(rd_data_o), 32'h00000000);
    check_val("tp_unmapped_err", 32'(err_o), 32'd1);
    rd_reg(8'h89);
`ifdef PWM_REG_ACTIVE_READBACK_EN
    check_val("tp_readback_arr0", 32'(rd_data_o), 32'h000003E8);
    check_val("tp_readback_noerr", 32'(err_o), 32'd0);
`else
    check_val("tp_readback_err", 32'(err_o), 32'd1);
`endif

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      sel = int'($urandom_range(0, 99));
      if (sel < 55)      ra = 8'(8 + 16 * $urandom_range(0, N - 1) + $urandom_range(0, 10));
      else if (sel < 63) ra = 8'd0;
      else if (sel < 75) ra = 8'd1;
      else if (sel < 83) ra = 8'd2;
      else if (sel < 93) ra = 8'($urandom_range(0, 255));
      else               ra = 8'(136 + 16 * $urandom_range(0, N - 1) + $urandom_range(0, 10));
      rdat = W'($urandom);
      if (ra == 8'd1) begin
        case ($urandom_range(0, 3))
          0:       rdat = 16'h00A5;
          1:       rdat = 16'h0055;
          2:       rdat = 16'h00AA;
          default: rdat = W'($urandom);
        endcase
      end
      rw   = ($urandom_range(0, 2) != 0);
      rr   = ($urandom_range(0, 1) != 0);
      rrst = ($urandom_range(0, 199) != 0);
      revt = ($urandom_range(0, 1) != 0) ? N'($urandom) : '0;
      cycle(rrst, rw, rr, ra, rdat, revt);
      if (lock_m != 0 && $urandom_range(0, 7) == 0) begin
        cycle(1'b1, 1'b1, 1'b0, 8'd1, 16'h0055, N'($urandom));
        cycle(1'b1, 1'b1, 1'b0, 8'd1, 16'h00AA, N'($urandom));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_register_bank.md
Name: pwm_register_bank

Overview:
Parametrised second-generation register file for the PWM subsystem, sitting between the I2C slave bus interface and the PWM cores.
- Supports NUM_CORES cores with 2 channels each.
- Keeps a preload (bus-visible) copy and an active (core-driving) copy of every timing register; preload is transferred to active on a per-core update event.
- Adds a key-sequence write lock, a sticky status/error register and registered read data.

Parameters:
WIDTH, 16, data width of counter/compare registers (must be >= 16)
NUM_CORES, 4, number of PWM cores, 1..7; channels = 2*NUM_CORES

Ports:
clk_psc_i  in  1  clock
rst_n_i  in  1  synchronous active-low reset
wr_en_i  in  1  write strobe, one transfer per cycle
rd_en_i  in  1  read strobe
addr_i  in  8  register address
wr_data_i  in  WIDTH  write data
rd_data_o  out  WIDTH  read data, valid when rd_valid_o=1
rd_valid_o  out  1  one-cycle pulse, cycle after rd_en_i
err_o  out  1  one-cycle pulse on rejected or unmapped access
update_evt_i  in  NUM_CORES  per-core counter-overflow pulse from cores
cen_o  out  NUM_CORES  counter enables
psc_o, arr_o  out  NUM_CORES*WIDTH  active prescaler / auto-reload, core c at [c*WIDTH +: WIDTH]
cmp_start_o, cmp_end_o  out  2*NUM_CORES*WIDTH  active compare values, channel k at [k*WIDTH +: WIDTH]
dtg_o, cfg_o  out  2*NUM_CORES*8  active dead-time / channel config, channel k at [k*8 +: 8]

Behaviour:
- Address map:
  - 0 CTRL: cen bits [NUM_CORES-1:0].
  - 1 KEY: write only; reads return 0.
  - 2 STATUS: [NUM_CORES-1:0] update-pending, [15] sticky err; W1C.
  - Core c window base B = 8 + 16*c:
    - B+0 PSC, B+1 ARR.
    - B+2..B+5 channel 2c: start, end, dtg, cfg.
    - B+6..B+9 channel 2c+1: start, end, dtg, cfg.
    - B+10 UPD: write any value forces a transfer; reads return 0.
  - All other addresses are unmapped.
- Reset (rst_n_i=0 at clock edge):
  - Preload and active: ARR all ones, PSC 0, cmp 0, cfg 0, dtg 1.
  - cen_o 0, STATUS 0, lock FSM UNLOCKED.
  - rd_data_o 0, rd_valid_o 0, err_o 0.
  - Reset mid-transaction discards the transaction.
- Writes: take effect at the clock edge where wr_en_i=1.
  - 8-bit fields take wr_data_i[7:0].
  - Any accepted write to core c window (except UPD) sets pending[c].
- Transfer to active, per core c: active <= preload and pending[c] cleared when any of:
  - update_evt_i[c]=1 and pending[c]=1
  - cen_o[c]=0 and pending[c]=1 (immediate shadow bypass while stopped; active changes 1 cycle after the write)
  - UPD write to core c
- Simultaneous write to core c preload and transfer for core c in the same cycle:
  - Active takes the pre-write preload value.
  - pending[c] remains 1 (set wins over clear).
- Reads: rd_en_i at edge N gives rd_data_o/rd_valid_o at edge N+1.
  - Returns preload values, zero-extended for 8-bit fields.
  - rd_data_o holds its last value when rd_valid_o=0.
  - Simultaneous rd_en_i and wr_en_i to the same address returns the old value.
- Lock FSM, driven by KEY writes:
  - UNLOCKED: KEY write 0x00A5 -> LOCKED.
  - LOCKED: KEY write 0x0055 -> KEY1.
  - KEY1: next write of any kind: KEY 0x00AA -> UNLOCKED; anything else -> LOCKED plus error.
  - In LOCKED/KEY1, writes to core windows are ignored and raise an error. CTRL, STATUS and KEY remain writable.
- Error: err_o pulses 1 cycle after the offending write/read, and sets STATUS[15].
  - Causes: unmapped access, locked write, bad key sequence.
  - Writing STATUS[15]=1 clears it; an error arriving in the same cycle wins.
- Width rules: CTRL ignores bits above NUM_CORES-1. No arithmetic; values are stored verbatim.

Optional Feature:
PWM_REG_ACTIVE_READBACK_EN
- Defined: a read at addr_i with bit 7 set and addr_i[6:0] mapping to a core window register returns the active copy. Such reads are not errors. Writes to addr[7]=1 are errors.
- Undefined: all addr[7]=1 addresses are unmapped; reads return 0 and pulse err_o.

Test Plan:
- Reset then read ARR core0 (addr 9) -> rd_valid_o next cycle, rd_data_o 0xFFFF; dtg ch0 (addr 12) reads 0x0001; err_o 0.
- cen_o=0, write PSC core1 (addr 24) 0x0010 -> psc_o[31:16]=0x0010 one cycle later, pending[1]=0.
- CTRL=0x1, write ARR core0 0x03E8 -> arr_o[15:0] stays 0xFFFF, STATUS=0x0001. Then pulse update_evt_i[0] -> arr_o[15:0]=0x03E8, STATUS=0x0000.
- Same-cycle write cmp_start ch0 0x0200 with update_evt_i[0] while pending -> active takes prior preload, pending stays 1; next event loads 0x0200.
- KEY 0x00A5, write addr 10 0x1234 -> ignored, err_o pulse, STATUS[15]=1. KEY 0x0055 then 0x00AA -> write accepted. KEY 0x0055 then a CTRL write -> stays LOCKED, err_o pulse.
- Read addr 200 -> rd_data_o 0, err_o pulse; with PWM_REG_ACTIVE_READBACK_EN, read 0x89 returns active ARR core0.
